// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared types for the Pong flow controller.
// Holds the FSM state encoding, the winner codes and the screen/enable
// decode used by game_flow_fsm.
package game_flow_pkg;

  typedef enum logic [2:0] {
    START = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Screen selects and clock enables, all decoded from one state.
  typedef struct packed {
    logic show_start;
    logic show_game;
    logic show_pause;
    logic show_over;
    logic game_en;
    logic menu_en;
  } screen_t;

  // The serve countdown is drawn on the game screen with the engine frozen.
  function automatic screen_t decode_screen(input game_state_t st);
    screen_t s;
    s = '0;
    case (st)
      START: begin
        s.show_start = 1'b1;
        s.menu_en    = 1'b1;
      end
      SERVE: s.show_game = 1'b1;
      PLAY: begin
        s.show_game = 1'b1;
        s.game_en   = 1'b1;
      end
      PAUSE: begin
        s.show_pause = 1'b1;
        s.menu_en    = 1'b1;
      end
      OVER: begin
        s.show_over = 1'b1;
        s.menu_en   = 1'b1;
      end
      default: begin
        s.show_start = 1'b1;
        s.menu_en    = 1'b1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/game_flow_fsm_button_edge.sv
// button_edge: registers the joystick button and produces a one-cycle,
// registered press strobe on its rising edge. The delayed copy resets to 1
// so a button held through reset is not seen as a new press.
module button_edge (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enter,
  output logic o_press
);

  logic r_enter_q;
  logic r_press;

  // Delay the button one cycle and register the rising-edge strobe.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_enter_q <= 1'b1;
      r_press   <= 1'b0;
    end else begin
      r_enter_q <= i_enter;
      r_press   <= i_enter & ~r_enter_q;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/game_flow_fsm.sv
// game_flow_fsm: Pong flow controller (START/SERVE/PLAY/PAUSE/OVER).
// Keeps score, detects the win, times the serve countdown, and drives
// registered clock enables, screen selects and the engine reset.
// Optional build macro GAME_FLOW_PAUSE_TIMEOUT_EN adds an idle timeout
// that returns from PAUSE to START after PAUSE_TIMEOUT frames.
module game_flow_fsm
  import game_flow_pkg::*;
#(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_FRAMES  = 60,
  parameter int PAUSE_TIMEOUT = 1800,
  parameter int SCORE_W       = $clog2(WIN_SCORE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               value,
  input  logic               frame_tick,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               game_en,
  output logic               menu_en,
  output logic               show_start,
  output logic               show_game,
  output logic               show_pause,
  output logic               show_over,
  output logic               game_rst_n,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner
);

  localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  game_state_t        r_state;
  game_state_t        w_state_next;
  screen_t            r_screen;
  screen_t            w_screen_next;
  logic               r_game_rst_n;
  logic               w_game_rst_n_next;
  logic               w_restart;
  logic [SCORE_W-1:0] r_score_p1;
  logic [SCORE_W-1:0] r_score_p2;
  logic [SCORE_W-1:0] w_score_p1_next;
  logic [SCORE_W-1:0] w_score_p2_next;
  logic [SCORE_W-1:0] w_p1_inc;
  logic [SCORE_W-1:0] w_p2_inc;
  logic [1:0]         r_winner;
  logic [1:0]         w_winner_next;
  logic [SERVE_W-1:0] r_serve_cnt;
  logic [SERVE_W-1:0] w_serve_cnt_next;
  logic               w_press;

`ifdef GAME_FLOW_PAUSE_TIMEOUT_EN
  localparam int IDLE_W = 16;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PAUSE_TIMEOUT - 1);
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_cnt_next;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (PAUSE_TIMEOUT != 0);
`endif

  button_edge u_button_edge (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_enter   (enter),
    .o_press   (w_press)
  );

  // Saturating increments keep a score from ever passing WIN_SCORE.
  assign w_p1_inc = (r_score_p1 >= WIN_VAL) ? r_score_p1 : r_score_p1 + SCORE_W'(1);
  assign w_p2_inc = (r_score_p2 >= WIN_VAL) ? r_score_p2 : r_score_p2 + SCORE_W'(1);

  // Next state, score/winner updates and countdown counters.
  always_comb begin
    w_state_next     = r_state;
    w_restart        = 1'b0;
    w_score_p1_next  = r_score_p1;
    w_score_p2_next  = r_score_p2;
    w_winner_next    = r_winner;
    w_serve_cnt_next = '0;
`ifdef GAME_FLOW_PAUSE_TIMEOUT_EN
    w_idle_cnt_next  = '0;
`endif
    case (r_state)
      START: begin
        if (w_press) w_state_next = SERVE;
      end
      SERVE: begin
        // The edge that samples the last tick is the edge that enters PLAY.
        if (frame_tick) begin
          if (r_serve_cnt == SERVE_LAST) w_state_next = PLAY;
          else w_serve_cnt_next = r_serve_cnt + SERVE_W'(1);
        end else begin
          w_serve_cnt_next = r_serve_cnt;
        end
      end
      PLAY: begin
        // A point always beats a coincident press; a double point replays.
        if (point_p1 && point_p2) begin
          w_state_next = SERVE;
        end else if (point_p1) begin
          w_score_p1_next = w_p1_inc;
          if (w_p1_inc == WIN_VAL) begin
            w_state_next  = OVER;
            w_winner_next = WIN_P1;
          end else begin
            w_state_next = SERVE;
          end
        end else if (point_p2) begin
          w_score_p2_next = w_p2_inc;
          if (w_p2_inc == WIN_VAL) begin
            w_state_next  = OVER;
            w_winner_next = WIN_P2;
          end else begin
            w_state_next = SERVE;
          end
        end else if (w_press) begin
          w_state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (w_press) begin
          if (value) w_restart = 1'b1;
          else w_state_next = SERVE;
        end
`ifdef GAME_FLOW_PAUSE_TIMEOUT_EN
        else if (frame_tick) begin
          if (r_idle_cnt == IDLE_LAST) w_restart = 1'b1;
          else w_idle_cnt_next = r_idle_cnt + IDLE_W'(1);
        end else begin
          w_idle_cnt_next = r_idle_cnt;
        end
`endif
      end
      OVER: begin
        if (w_press) w_restart = 1'b1;
      end
      default: w_restart = 1'b1;
    endcase
    // Every restart path shares the same clearing actions.
    if (w_restart) begin
      w_state_next    = START;
      w_score_p1_next = '0;
      w_score_p2_next = '0;
      w_winner_next   = WIN_NONE;
    end
  end

  // Output decode from the state being entered, so registered outputs line up with it.
  always_comb begin
    w_screen_next     = decode_screen(w_state_next);
    w_game_rst_n_next = ~w_restart;
  end

  // State, score and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= START;
      r_screen     <= decode_screen(START);
      r_game_rst_n <= 1'b0;
      r_score_p1   <= '0;
      r_score_p2   <= '0;
      r_winner     <= WIN_NONE;
      r_serve_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_screen     <= w_screen_next;
      r_game_rst_n <= w_game_rst_n_next;
      r_score_p1   <= w_score_p1_next;
      r_score_p2   <= w_score_p2_next;
      r_winner     <= w_winner_next;
      r_serve_cnt  <= w_serve_cnt_next;
    end
  end

`ifdef GAME_FLOW_PAUSE_TIMEOUT_EN
  // Idle frame counter for the PAUSE timeout; zero outside PAUSE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_idle_cnt <= '0;
    else r_idle_cnt <= w_idle_cnt_next;
  end
`endif

  assign show_start = r_screen.show_start;
  assign show_game  = r_screen.show_game;
  assign show_pause = r_screen.show_pause;
  assign show_over  = r_screen.show_over;
  assign game_en    = r_screen.game_en;
  assign menu_en    = r_screen.menu_en;
  assign game_rst_n = r_game_rst_n;
  assign score_p1   = r_score_p1;
  assign score_p2   = r_score_p2;
  assign winner     = r_winner;

endmodule

// File: tb/tb_game_flow_fsm.sv
// tb_game_flow_fsm: scoreboard bench for game_flow_fsm.
// Stimulus tasks push the expected output snapshot and the cycle at which it
// must appear; a monitor pops one entry each time any DUT output changes.
module tb_game_flow_fsm;

  localparam int SF = 60;
  localparam int S_START = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enter = 1'b0;
  logic value = 1'b0;
  logic frame_tick = 1'b0;
  logic point_p1 = 1'b0;
  logic point_p2 = 1'b0;
  logic game_en, menu_en, show_start, show_game, show_pause, show_over, game_rst_n;
  logic [2:0] score_p1, score_p2;
  logic [1:0] winner;

  game_flow_fsm #(
    .WIN_SCORE     (7),
    .SERVE_FRAMES  (SF),
    .PAUSE_TIMEOUT (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enter      (enter),
    .value      (value),
    .frame_tick (frame_tick),
    .point_p1   (point_p1),
    .point_p2   (point_p2),
    .game_en    (game_en),
    .menu_en    (menu_en),
    .show_start (show_start),
    .show_game  (show_game),
    .show_pause (show_pause),
    .show_over  (show_over),
    .game_rst_n (game_rst_n),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .winner     (winner)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] v;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Snapshot: {show_start, show_game, show_pause, show_over, game_en, menu_en, game_rst_n, s1, s2, winner}
  function automatic logic [14:0] mk(int st, logic rstn, logic [2:0] s1, logic [2:0] s2, logic [1:0] w);
    logic [5:0] scr;
    case (st)
      S_START: scr = 6'b100001;
      S_SERVE: scr = 6'b010000;
      S_PLAY:  scr = 6'b010010;
      S_PAUSE: scr = 6'b001001;
      S_OVER:  scr = 6'b000101;
      default: scr = 6'b000000;
    endcase
    return {scr, rstn, s1, s2, w};
  endfunction

  task automatic expect_at(string t, int c, logic [14:0] ev);
    sb.push_back('{v: ev, cyc: c, tag: t});
  endtask

  // Monitor: every output change is one transaction.
  logic [14:0] mon_prev;
  logic [14:0] mon_obs;
  exp_t        mon_e;
  initial begin
    mon_prev = 'x;
    forever begin
      @(negedge clock);
      mon_obs = {show_start, show_game, show_pause, show_over, game_en, menu_en,
                 game_rst_n, score_p1, score_p2, winner};
      if (mon_obs !== mon_prev) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required no change", mon_obs, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_obs !== mon_e.v || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
            n_fail++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     mon_e.tag, mon_obs, cyc, mon_e.v, mon_e.cyc);
          end else begin
            $display("ok   %s: %b at cycle %0d", mon_e.tag, mon_obs, cyc);
          end
        end
      end
      mon_prev = mon_obs;
    end
  end

  // Press producing a normal transition, visible two edges after enter rises.
  task automatic do_press(logic v, string t, logic [14:0] ev);
    int n;
    n = cyc;
    value = v;
    expect_at(t, n + 2, ev);
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    @(negedge clock);
  endtask

  // Press producing a restart: START, cleared scores, one-cycle game reset.
  task automatic do_restart(logic v, string t);
    int n;
    n = cyc;
    value = v;
    expect_at(t, n + 2, mk(S_START, 1'b0, 3'd0, 3'd0, 2'b00));
    expect_at({t, "_rst_rise"}, n + 3, mk(S_START, 1'b1, 3'd0, 3'd0, 2'b00));
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_point(logic a, logic b, string t, logic [14:0] ev);
    int n;
    n = cyc;
    expect_at(t, n + 1, ev);
    point_p1 = a;
    point_p2 = b;
    @(negedge clock);
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  // Exactly SF ticks; PLAY must appear on the edge sampling the last one.
  task automatic serve_to_play(logic [2:0] s1, logic [2:0] s2);
    int n;
    n = cyc;
    expect_at("serve_done", n + SF, mk(S_PLAY, 1'b1, s1, s2, 2'b00));
    repeat (SF) begin
      frame_tick = 1'b1;
      @(negedge clock);
    end
    frame_tick = 1'b0;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    summary();
    $finish;
  end

  initial begin
    int n;
    expect_at("reset", -1, mk(S_START, 1'b0, 3'd0, 3'd0, 2'b00));
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    expect_at("rst_release", cyc + 1, mk(S_START, 1'b1, 3'd0, 3'd0, 2'b00));
    repeat (2) @(negedge clock);

    // Match won by player 1.
    do_press(1'b0, "start_to_serve", mk(S_SERVE, 1'b1, 3'd0, 3'd0, 2'b00));
    serve_to_play(3'd0, 3'd0);
    for (int i = 1; i <= 7; i++) begin
      if (i < 7) begin
        do_point(1'b1, 1'b0, "p1_point", mk(S_SERVE, 1'b1, 3'(i), 3'd0, 2'b00));
        serve_to_play(3'(i), 3'd0);
      end else begin
        do_point(1'b1, 1'b0, "p1_wins", mk(S_OVER, 1'b1, 3'd7, 3'd0, 2'b01));
      end
    end
    point_p1 = 1'b1;
    @(negedge clock);
    point_p1 = 1'b0;
    repeat (3) @(negedge clock);
    do_restart(1'b0, "over_restart");

    // Double point, alternating points, point beating a press.
    do_press(1'b0, "start_to_serve2", mk(S_SERVE, 1'b1, 3'd0, 3'd0, 2'b00));
    serve_to_play(3'd0, 3'd0);
    do_point(1'b1, 1'b1, "tie_replay", mk(S_SERVE, 1'b1, 3'd0, 3'd0, 2'b00));
    serve_to_play(3'd0, 3'd0);
    do_point(1'b1, 1'b0, "p1_1_0", mk(S_SERVE, 1'b1, 3'd1, 3'd0, 2'b00));
    serve_to_play(3'd1, 3'd0);
    do_point(1'b0, 1'b1, "p2_1_1", mk(S_SERVE, 1'b1, 3'd1, 3'd1, 2'b00));
    serve_to_play(3'd1, 3'd1);
    do_point(1'b1, 1'b0, "p1_2_1", mk(S_SERVE, 1'b1, 3'd2, 3'd1, 2'b00));
    serve_to_play(3'd2, 3'd1);
    do_point(1'b0, 1'b1, "p2_2_2", mk(S_SERVE, 1'b1, 3'd2, 3'd2, 2'b00));
    serve_to_play(3'd2, 3'd2);
    n = cyc;
    expect_at("point_beats_press", n + 2, mk(S_SERVE, 1'b1, 3'd3, 3'd2, 2'b00));
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    point_p1 = 1'b1;
    @(negedge clock);
    point_p1 = 1'b0;
    serve_to_play(3'd3, 3'd2);

    // Pause: continue keeps the score, restart clears it.
    do_press(1'b0, "pause", mk(S_PAUSE, 1'b1, 3'd3, 3'd2, 2'b00));
    do_press(1'b0, "continue", mk(S_SERVE, 1'b1, 3'd3, 3'd2, 2'b00));
    serve_to_play(3'd3, 3'd2);
    do_press(1'b0, "pause2", mk(S_PAUSE, 1'b1, 3'd3, 3'd2, 2'b00));
    do_restart(1'b1, "pause_restart");

    // Idle ticks in PAUSE.
    do_press(1'b0, "start_to_serve3", mk(S_SERVE, 1'b1, 3'd0, 3'd0, 2'b00));
    serve_to_play(3'd0, 3'd0);
    do_point(1'b1, 1'b0, "p1_again", mk(S_SERVE, 1'b1, 3'd1, 3'd0, 2'b00));
    serve_to_play(3'd1, 3'd0);
    do_press(1'b0, "pause3", mk(S_PAUSE, 1'b1, 3'd1, 3'd0, 2'b00));
`ifdef GAME_FLOW_PAUSE_TIMEOUT_EN
    n = cyc;
    expect_at("pause_timeout", n + 4, mk(S_START, 1'b0, 3'd0, 3'd0, 2'b00));
    expect_at("pause_timeout_rst_rise", n + 5, mk(S_START, 1'b1, 3'd0, 3'd0, 2'b00));
`endif
    repeat (10) begin
      frame_tick = 1'b1;
      @(negedge clock);
    end
    frame_tick = 1'b0;
`ifndef GAME_FLOW_PAUSE_TIMEOUT_EN
    do_restart(1'b1, "pause_restart2");
`endif

    // Button held for 100 cycles: one transition, SERVE is not left.
    n = cyc;
    expect_at("held_enter", n + 2, mk(S_SERVE, 1'b1, 3'd0, 3'd0, 2'b00));
    enter = 1'b1;
    repeat (100) @(negedge clock);
    enter = 1'b0;
    repeat (5) @(negedge clock);

    // Asynchronous reset mid-match, asserted between edges.
    serve_to_play(3'd0, 3'd0);
    do_point(1'b0, 1'b1, "p2_point", mk(S_SERVE, 1'b1, 3'd0, 3'd1, 2'b00));
    @(posedge clock);
    #1;
    expect_at("async_reset", cyc, mk(S_START, 1'b0, 3'd0, 3'd0, 2'b00));
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    expect_at("async_release", cyc + 1, mk(S_START, 1'b1, 3'd0, 3'd0, 2'b00));
    repeat (5) @(negedge clock);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0 (next %s)",
               sb.size(), sb[0].tag);
    end
    summary();
    $finish;
  end

endmodule
